instruction_fetch_unit: RTL and testbench



---
 rtl/instruction_fetch_unit_pkg.sv | 27 ++
 rtl/instruction_fetch_unit_fetch_fifo.sv | 53 +++++
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch/decode definitions: reset PC, NOP encoding, opcode map, fetch entry layout.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  localparam logic [6:0] OP_R       = 7'h33;
  localparam logic [6:0] OP_I_LOGIC = 7'h13;
  localparam logic [6:0] OP_I_LOAD  = 7'h03;
  localparam logic [6:0] OP_I_JUMP  = 7'h67;
  localparam logic [6:0] OP_U       = 7'h37;
  localparam logic [6:0] OP_J       = 7'h6F;
  localparam logic [6:0] OP_S       = 7'h23;
  localparam logic [6:0] OP_B       = 7'h63;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// DEPTH-entry FIFO with occupancy count and synchronous flush; flush beats push/pop.
module instruction_fetch_unit_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (push_i && !pop_i && !flush_i) |-> (cnt_q != FULL_CNT));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order word fetches over req/gnt/rvalid,
// buffers returned words for decode and discards fetches made stale by a redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Redirect_i,
  input  logic [31:0] Redirect_PC_i,
  output logic        Imem_Req_o,
  output logic [31:0] Imem_Addr_o,
  input  logic        Imem_Gnt_i,
  input  logic        Imem_Rvalid_i,
  input  logic [31:0] Imem_Rdata_i,
  output logic        Instr_Valid_o,
  input  logic        Instr_Ready_i,
  output logic [31:0] Instr_o,
  output logic [31:0] Instr_PC_o,
  output logic [6:0]  OP_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  ifu_state_e    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] pcq_cnt, buf_cnt, live_after;
  logic [31:0]   pcq_head;
  fetch_entry_t  buf_head, buf_wdata;
  logic          issue, rsp_drop, rsp_live, pop;

  // Live fetches in flight plus buffered words never exceed DEPTH, so the buffer cannot overflow.
  assign Imem_Req_o  = (state_q == RUN) && (({1'b0, pcq_cnt} + {1'b0, buf_cnt}) < LIMIT);
  assign Imem_Addr_o = fetch_pc_q;

  assign issue      = Imem_Req_o & Imem_Gnt_i;
  assign rsp_drop   = Imem_Rvalid_i & (drop_q != '0);
  assign rsp_live   = Imem_Rvalid_i & (drop_q == '0);
  assign pop        = Instr_Valid_o & Instr_Ready_i & ~Redirect_i;
  assign live_after = pcq_cnt + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, rsp_live};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q - {{(CW-1){1'b0}}, rsp_drop};
    if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
    // Everything still in flight after this cycle becomes stale on a redirect.
    if (Redirect_i) begin
      drop_d     = drop_d + live_after;
      fetch_pc_d = Redirect_PC_i & 32'hFFFF_FFFC;
    end
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (Redirect_i && (drop_d != '0)) state_d = FLUSH;
      FLUSH:   if (drop_d == '0) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  instruction_fetch_unit_fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pc_q (
    .clk     (clk),
    .reset   (reset),
    .flush_i (Redirect_i),
    .push_i  (issue),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp_live),
    .head_o  (pcq_head),
    .count_o (pcq_cnt)
  );

  assign buf_wdata = '{pc: pcq_head, instr: Imem_Rdata_i};

  instruction_fetch_unit_fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_ibuf (
    .clk     (clk),
    .reset   (reset),
    .flush_i (Redirect_i),
    .push_i  (rsp_live & ~Redirect_i),
    .data_i  (buf_wdata),
    .pop_i   (pop),
    .head_o  (buf_head),
    .count_o (buf_cnt)
  );

  assign Instr_Valid_o = (buf_cnt != '0);
  assign Instr_o       = Instr_Valid_o ? buf_head.instr : NOP_INSTR;
  assign Instr_PC_o    = Instr_Valid_o ? buf_head.pc    : RESET_PC;
  assign OP_o          = Instr_o[6:0];

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    Imem_Rvalid_i |-> ((drop_q != '0) || (pcq_cnt != '0)));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a stream-level fetch model plus directed pins.
module tb_instruction_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic clk = 1'b0, reset = 1'b0;
  logic Redirect_i = 1'b0;
  logic [31:0] Redirect_PC_i = '0;
  logic Imem_Req_o;
  logic [31:0] Imem_Addr_o;
  logic Imem_Gnt_i = 1'b0, Imem_Rvalid_i = 1'b0;
  logic [31:0] Imem_Rdata_i = '0;
  logic Instr_Valid_o, Instr_Ready_i = 1'b0;
  logic [31:0] Instr_o, Instr_PC_o;
  logic [6:0] OP_o;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Redirect_i(Redirect_i), .Redirect_PC_i(Redirect_PC_i),
    .Imem_Req_o(Imem_Req_o), .Imem_Addr_o(Imem_Addr_o), .Imem_Gnt_i(Imem_Gnt_i),
    .Imem_Rvalid_i(Imem_Rvalid_i), .Imem_Rdata_i(Imem_Rdata_i), .Instr_Valid_o(Instr_Valid_o),
    .Instr_Ready_i(Instr_Ready_i), .Instr_o(Instr_o), .Instr_PC_o(Instr_PC_o), .OP_o(OP_o)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic [6:0] op; int cyc; } acc_t;

  mreq_t       memq[$];
  acc_t        acc[$];
  logic [31:0] grants[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, n_acc = 0;
  int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1, redir_pm = 0;

  // Stream model: next fetch address, next PC decode should see, and fetch bookkeeping.
  logic [31:0] m_fetch = RPC, m_head = RPC, w;
  int  m_outst = 0, m_stale = 0, m_inflight = 0, m_buf = 0;
  bit  m_idle = 1'b1, exp_req, grant, popv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h0050_0093;
    if (a == 32'h0040_0004) return 32'h0020_8133;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_req",   32'(Imem_Req_o), 32'd0);
      chk("rst_addr",  Imem_Addr_o, RPC);
      chk("rst_valid", 32'(Instr_Valid_o), 32'd0);
      chk("rst_instr", Instr_o, 32'h0000_0013);
      chk("rst_pc",    Instr_PC_o, RPC);
      chk("rst_op",    32'(OP_o), 32'h13);
      m_fetch = RPC; m_head = RPC; m_outst = 0; m_stale = 0; m_inflight = 0; m_buf = 0;
      m_idle = 1'b1;
      memq.delete();
    end else begin
      exp_req = !m_idle && (m_stale == 0) && ((m_inflight + m_buf) < DEPTH);
      chk("req",   32'(Imem_Req_o), 32'(exp_req));
      chk("valid", 32'(Instr_Valid_o), 32'(m_buf > 0));
      if (Imem_Req_o) chk("addr", Imem_Addr_o, m_fetch);
      if (Instr_Valid_o) begin
        w = mem_word(m_head);
        chk("pc",    Instr_PC_o, m_head);
        chk("instr", Instr_o, w);
        chk("op",    32'(OP_o), 32'(w[6:0]));
      end
      grant = Imem_Req_o && Imem_Gnt_i;
      popv  = Instr_Valid_o && Instr_Ready_i;
      if (grant) begin
        memq.push_back('{Imem_Addr_o, cyc + int'($urandom_range(lat_max, lat_min))});
        grants.push_back(Imem_Addr_o);
      end
      m_outst = m_outst + int'(grant) - int'(Imem_Rvalid_i);
      if (Redirect_i) begin
        m_stale = m_outst; m_inflight = 0; m_buf = 0;
        m_fetch = Redirect_PC_i & 32'hFFFF_FFFC;
        m_head  = m_fetch;
      end else begin
        if (grant) begin m_inflight++; m_fetch = m_fetch + 32'd4; end
        if (Imem_Rvalid_i) begin
          if (m_stale > 0) m_stale--;
          else begin m_inflight--; m_buf++; end
        end
        if (popv && m_buf > 0) begin
          acc.push_back('{Instr_PC_o, Instr_o, OP_o, cyc});
          n_acc++;
          m_buf--;
          m_head = m_head + 32'd4;
        end
      end
      m_idle = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    Imem_Gnt_i    = ($urandom_range(99) < gnt_pct);
    Instr_Ready_i = ($urandom_range(99) < rdy_pct);
    Redirect_i    = 1'b0;
    if ($urandom_range(999) < redir_pm) begin
      Redirect_i = 1'b1;
      case ($urandom_range(3))
        0: Redirect_PC_i = $urandom;
        1: Redirect_PC_i = 32'hFFFF_FFF0 + 32'($urandom_range(15));
        2: Redirect_PC_i = RPC + 32'($urandom_range(255));
        default: Redirect_PC_i = $urandom & 32'h0000_0FFF;
      endcase
    end
    Imem_Rvalid_i = 1'b0;
    Imem_Rdata_i  = $urandom;
    if (!reset && memq.size() > 0 && memq[0].due <= cyc) begin
      Imem_Rvalid_i = 1'b1;
      Imem_Rdata_i  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    step(); reset = 1'b1;
    steps(2);
    step(); reset = 1'b0;
  endtask

  task automatic redirect_now(input logic [31:0] tgt);
    step(); Redirect_i = 1'b1; Redirect_PC_i = tgt;
    @(negedge clk); #1;
    acc.delete(); grants.delete();
  endtask

  int c_rel, n_before;
  logic [31:0] a0;
  bit hit;

  initial begin
    #1 reset = 1'b1;
    steps(3);
    step(); reset = 1'b0; c_rel = cyc;
    chk("t1_idle_req", 32'(Imem_Req_o), 32'd0);
    step();
    chk("t1_req", 32'(Imem_Req_o), 32'd1);
    chk("t1_addr", Imem_Addr_o, 32'h0040_0000);
    steps(8);
    chk("t2_count", 32'(acc.size() >= 2), 32'd1);
    if (acc.size() >= 2) begin
      chk("t2_pc0", acc[0].pc, 32'h0040_0000);
      chk("t2_ins0", acc[0].instr, 32'h0050_0093);
      chk("t2_op0", 32'(acc[0].op), 32'h13);
      chk("t2_pc1", acc[1].pc, 32'h0040_0004);
      chk("t2_op1", 32'(acc[1].op), 32'h33);
      chk("t2_b2b", 32'(acc[1].cyc - acc[0].cyc), 32'd1);
      chk("t2_lat", 32'(acc[0].cyc - c_rel), 32'd3);
    end

    // Mid-run reset with decode stalled: buffer fills to DEPTH and requests stop.
    rdy_pct = 0;
    do_reset();
    acc.delete();
    chk("t1b_idle_req", 32'(Imem_Req_o), 32'd0);
    steps(6);
    chk("t3_req_off", 32'(Imem_Req_o), 32'd0);
    chk("t3_valid", 32'(Instr_Valid_o), 32'd1);
    chk("t3_nopop", 32'(acc.size()), 32'd0);
    rdy_pct = 100;
    steps(8);
    chk("t3_count", 32'(acc.size() >= 3), 32'd1);
    if (acc.size() >= 3) begin
      chk("t3_pc0", acc[0].pc, 32'h0040_0000);
      chk("t3_pc1", acc[1].pc, 32'h0040_0004);
      chk("t3_pc2", acc[2].pc, 32'h0040_0008);
    end

    // Grant withheld: request and address must hold until granted.
    gnt_pct = 0;
    steps(3);
    a0 = Imem_Addr_o;
    chk("t4_req0", 32'(Imem_Req_o), 32'd1);
    steps(3);
    chk("t4_req_hold", 32'(Imem_Req_o), 32'd1);
    chk("t4_addr_hold", Imem_Addr_o, a0);
    gnt_pct = 100;
    steps(2);
    chk("t4_addr_adv", Imem_Addr_o, a0 + 32'd4);

    // Latency 3 with two stale fetches in flight at the redirect.
    lat_min = 3; lat_max = 3;
    do_reset();
    steps(2);
    redirect_now(32'h0040_0102);
    step();
    chk("t5_flush_req", 32'(Imem_Req_o), 32'd0);
    chk("t5_flush_valid", 32'(Instr_Valid_o), 32'd0);
    steps(12);
    chk("t5_count", 32'(acc.size() >= 1 && grants.size() >= 1), 32'd1);
    if (acc.size() >= 1 && grants.size() >= 1) begin
      chk("t5_grant0", grants[0], 32'h0040_0100);
      chk("t5_pc0", acc[0].pc, 32'h0040_0100);
    end

    // Address wrap at the top of the address space.
    lat_min = 1; lat_max = 1;
    redirect_now(32'hFFFF_FFFC);
    steps(12);
    chk("t6_count", 32'(acc.size() >= 2 && grants.size() >= 2), 32'd1);
    if (acc.size() >= 2 && grants.size() >= 2) begin
      chk("t6_g0", grants[0], 32'hFFFF_FFFC);
      chk("t6_g1", grants[1], 32'h0000_0000);
      chk("t6_pc0", acc[0].pc, 32'hFFFF_FFFC);
      chk("t6_pc1", acc[1].pc, 32'h0000_0000);
    end

    // Redirect in the same cycle as a response: that word must never reach decode.
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step();
      if (Imem_Rvalid_i) begin
        Redirect_i = 1'b1; Redirect_PC_i = 32'h0000_1000; hit = 1'b1;
      end
    end
    chk("t6_rsp_seen", 32'(hit), 32'd1);
    @(negedge clk); #1;
    acc.delete();
    steps(12);
    chk("t6_rd_count", 32'(acc.size() >= 1), 32'd1);
    if (acc.size() >= 1) chk("t6_rd_pc0", acc[0].pc, 32'h0000_1000);

    // Random traffic against the stream model.
    gnt_pct = 70; rdy_pct = 60; lat_min = 1; lat_max = 5; redir_pm = 25;
    n_before = n_acc;
    steps(4000);
    chk("rand_progress", 32'((n_acc - n_before) >= 200), 32'd1);

    redir_pm = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
